// File: rtl/tetris_input_queue_if.sv
// Processor-facing port bundle of the button event queue: pop/clear strobes in, head event and status out.
interface tetris_input_queue_if #(
  parameter int PTR_W = 3
);
  logic             pop;
  logic             clr_ovf;
  logic [31:0]      rd_data;
  logic             empty;
  logic             full;
  logic [PTR_W:0]   count;
  logic             overflow;

  modport master (output pop, clr_ovf, input rd_data, empty, full, count, overflow);
  modport slave  (input pop, clr_ovf, output rd_data, empty, full, count, overflow);
endinterface

// File: rtl/tetris_input_queue.sv
// Debounced, edge-detected button events queued in a first-word-fall-through FIFO
// that the processor drains with a memory-mapped load.
module tetris_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, stable, stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 == stable)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end

  // Only presses matter; releases are swallowed here.
  assign rise = stable & ~stable_q;
endmodule

module tetris_input_queue #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 8,
  parameter int PTR_W           = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            btn_in,
  tetris_input_queue_if.slave   bus
);
  logic [3:0]       rise, pend, grant;
  logic [2:0]       code;
  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty, full, push, push_ok, pop_ok, drop;

  tetris_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [3:0] (
    .clock (clock),
    .reset (reset),
    .btn   (btn_in),
    .rise  (rise)
  );

  // Descending scan so the lowest-index pending button ends up granted.
  always_comb begin
    grant = '0;
    code  = '0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        code     = 3'(i + 1);
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign push    = |pend;
  assign pop_ok  = bus.pop & ~empty;
  assign push_ok = push & (~full | bus.pop);
  assign drop    = push & full & ~bus.pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | rise;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (drop)             bus.overflow <= 1'b1;
      else if (bus.clr_ovf) bus.overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= code;
  end

  assign bus.rd_data = empty ? 32'd0 : {29'd0, mem[rd_ptr]};
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count;
endmodule

// File: tb/tb_tetris_input_queue.sv
// Directed scenarios with hand-derived expectations, plus a randomized run checked against a queue-based reference model.
module tb_tetris_input_queue;
  localparam int DC    = 16;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'd0;
  int errs   = 0;
  int checks = 0;

  tetris_input_queue_if #(.PTR_W(PTR_W)) bus ();

  tetris_input_queue #(.DEBOUNCE_CYCLES(DC), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock  (clk),
    .reset  (rst),
    .btn_in (btn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 2-cycle input delay, per-button "DC consecutive differing
  // samples flips the level", press -> pending flag -> FIFO held as a queue.
  bit [3:0] m_s1, m_s2, m_stab, m_stabq, m_pend;
  int       m_run [4];
  int       m_q [$];
  bit       m_ovf;

  task automatic model_step(input bit r, input bit [3:0] b, input bit p, input bit c);
    int idx;
    bit [3:0] rise;
    bit was_full, was_empty;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_stab = 0; m_stabq = 0; m_pend = 0; m_ovf = 0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_q.delete();
      return;
    end
    idx = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i] && idx < 0) idx = i;
    rise      = m_stab & ~m_stabq;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    if (p && !was_empty) void'(m_q.pop_front());
    if (idx >= 0 && (!was_full || p)) m_q.push_back(idx + 1);
    if (idx >= 0 && was_full && !p) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (idx >= 0) m_pend[idx] = 0;
    m_pend  = m_pend | rise;
    m_stabq = m_stab;
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] == m_stab[i]) m_run[i] = 0;
      else if (m_run[i] + 1 == DC) begin m_stab[i] = ~m_stab[i]; m_run[i] = 0; end
      else m_run[i]++;
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, btn, bus.pop, bus.clr_ovf);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input bit [3:0] b, input int hold, input int rel);
    btn = b; ticks(hold);
    btn = 4'd0; ticks(rel);
  endtask

  task automatic do_pop();
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ticks(2); rst = 1'b0;
    checks++;
    if ({bus.empty, bus.full, bus.count, bus.overflow, bus.rd_data} !== {1'b1, 1'b0, 4'd0, 1'b0, 32'd0}) begin
      errs++;
      $display("FAIL reset_state: empty=%b full=%b count=%0d ovf=%b rd=%0d, want 1 0 0 0 0",
               bus.empty, bus.full, bus.count, bus.overflow, bus.rd_data);
    end
    ticks(3);
  endtask

  task automatic test_single_press();
    btn = 4'b0001;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 19) begin
        checks++;
        if (bus.empty !== 1'b1) begin errs++; $display("FAIL latency_early: empty=%b after edge 19, want 1", bus.empty); end
      end
      if (k == 20) begin
        checks++;
        if (bus.empty !== 1'b0 || bus.rd_data !== 32'd1) begin
          errs++; $display("FAIL latency_edge20: empty=%b rd=%0d, want 0 1", bus.empty, bus.rd_data);
        end
      end
    end
    do_pop();
    checks++;
    if (bus.empty !== 1'b1 || bus.rd_data !== 32'd0) begin
      errs++; $display("FAIL single_pop: empty=%b rd=%0d, want 1 0", bus.empty, bus.rd_data);
    end
    ticks(20);
    checks++;
    if (bus.count !== 4'd0) begin errs++; $display("FAIL held_no_repeat: count=%0d, want 0", bus.count); end
    btn = 4'd0; ticks(22);
  endtask

  task automatic test_glitch();
    int maxc = 0;
    btn = 4'b0100;
    for (int k = 0; k < 10; k++) begin tick(); if (int'(bus.count) > maxc) maxc = int'(bus.count); end
    btn = 4'b0000;
    for (int k = 0; k < 30; k++) begin tick(); if (int'(bus.count) > maxc) maxc = int'(bus.count); end
    checks++;
    if (maxc !== 0) begin errs++; $display("FAIL glitch: max count=%0d, want 0", maxc); end
  endtask

  task automatic test_simultaneous();
    btn = 4'b1010; ticks(30);
    checks++;
    if (bus.count !== 4'd2 || bus.rd_data !== 32'd2) begin
      errs++; $display("FAIL simul_first: count=%0d rd=%0d, want 2 2", bus.count, bus.rd_data);
    end
    do_pop();
    checks++;
    if (bus.count !== 4'd1 || bus.rd_data !== 32'd4) begin
      errs++; $display("FAIL simul_second: count=%0d rd=%0d, want 1 4", bus.count, bus.rd_data);
    end
    do_pop();
    checks++;
    if (bus.count !== 4'd0) begin errs++; $display("FAIL simul_drain: count=%0d, want 0", bus.count); end
    btn = 4'd0; ticks(22);
  endtask

  task automatic test_overflow();
    for (int n = 0; n < 9; n++) press(4'b0001, 20, 22);
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_fill: count=%0d full=%b ovf=%b, want 8 1 1", bus.count, bus.full, bus.overflow);
    end
    for (int n = 0; n < 8; n++) begin
      checks++;
      if (bus.rd_data !== 32'd1) begin errs++; $display("FAIL ovf_drain%0d: rd=%0d, want 1", n, bus.rd_data); end
      do_pop();
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      errs++; $display("FAIL ovf_empty: empty=%b ovf=%b, want 1 1", bus.empty, bus.overflow);
    end
    bus.clr_ovf = 1'b1; tick(); bus.clr_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear: ovf=%b, want 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int n = 0; n < 8; n++) press(4'b0010, 20, 22);
    btn = 4'b0001; ticks(19);
    bus.pop = 1'b1; tick(); bus.pop = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
      errs++; $display("FAIL full_push_pop: count=%0d full=%b ovf=%b, want 8 1 0", bus.count, bus.full, bus.overflow);
    end
    btn = 4'd0; ticks(22);
    for (int n = 0; n < 7; n++) do_pop();
    checks++;
    if (bus.rd_data !== 32'd1) begin errs++; $display("FAIL full_tail: rd=%0d, want 1", bus.rd_data); end
    do_pop();
    checks++;
    if (bus.empty !== 1'b1) begin errs++; $display("FAIL full_drain: empty=%b, want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    int maxc = 0;
    for (int n = 0; n < 3; n++) press(4'b0010, 20, 22);
    checks++;
    if (bus.count !== 4'd3) begin errs++; $display("FAIL mid_prefill: count=%0d, want 3", bus.count); end
    btn = 4'b1000; ticks(8);
    rst = 1'b1; btn = 4'd0; tick(); rst = 1'b0;
    checks++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 32'd0) begin
      errs++; $display("FAIL mid_reset: count=%0d empty=%b rd=%0d, want 0 1 0", bus.count, bus.empty, bus.rd_data);
    end
    for (int k = 0; k < 40; k++) begin tick(); if (int'(bus.count) > maxc) maxc = int'(bus.count); end
    checks++;
    if (maxc !== 0) begin errs++; $display("FAIL mid_quiet: max count=%0d, want 0", maxc); end
    btn = 4'b1000; ticks(25);
    checks++;
    if (bus.count !== 4'd1 || bus.rd_data !== 32'd4) begin
      errs++; $display("FAIL mid_repress: count=%0d rd=%0d, want 1 4", bus.count, bus.rd_data);
    end
    do_pop();
    btn = 4'd0; ticks(22);
  endtask

  task automatic test_random();
    int hold = 0;
    int exp_rd;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        btn  = 4'($urandom_range(0, 15));
        hold = $urandom_range(2, 40);
      end
      hold--;
      bus.pop     = ($urandom_range(0, 7) == 0);
      bus.clr_ovf = ($urandom_range(0, 15) == 0);
      tick();
      exp_rd = (m_q.size() != 0) ? m_q[0] : 0;
      checks++;
      if ({bus.count, bus.rd_data, bus.overflow, bus.empty, bus.full} !==
          {4'(m_q.size()), 32'(exp_rd), m_ovf, 1'(m_q.size() == 0), 1'(m_q.size() == DEPTH)}) begin
        errs++;
        $display("FAIL random_cyc%0d: count=%0d rd=%0d ovf=%b empty=%b full=%b, want %0d %0d %b",
                 k, bus.count, bus.rd_data, bus.overflow, bus.empty, bus.full, m_q.size(), exp_rd, m_ovf);
      end
    end
    bus.pop = 1'b0; bus.clr_ovf = 1'b0; btn = 4'd0;
  endtask

  initial begin
    bus.pop     = 1'b0;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
